btle_vco: RTL and testbench
===========================

Name: btle_vco

Overview:
- Digital voltage-controlled oscillator for the BTLE GFSK transmitter. Sits after the Gaussian filter and before the IQ DAC interface.
- Integrates a signed frequency ("voltage") sample into a wrapping phase accumulator.
- Converts the phase to cos/sin by looking up two runtime-loadable tables held in dual-port RAMs.
- Produces one cos/sin pair per valid input sample.

Parameters:
VCO_BIT_WIDTH, 16, width of voltage_signal and of the phase accumulator
SIN_COS_ADDR_BIT_WIDTH, 11, table address width; each table has 2^11 = 2048 entries
IQ_BIT_WIDTH, 8, signed width of table entries and of cos_out/sin_out

Ports:
clk  in  1  clock (system runs it at 16 MHz)
rst  in  1  synchronous, active-high reset
cos_table_write_address  in  SIN_COS_ADDR_BIT_WIDTH  cos table write address
cos_table_write_data  in  IQ_BIT_WIDTH (signed)  cos table write data
sin_table_write_address  in  SIN_COS_ADDR_BIT_WIDTH  sin table write address
sin_table_write_data  in  IQ_BIT_WIDTH (signed)  sin table write data
voltage_signal  in  VCO_BIT_WIDTH (signed)  phase increment per sample
voltage_signal_valid  in  1  qualifies voltage_signal
cos_out  out  IQ_BIT_WIDTH (signed)  cosine sample
sin_out  out  IQ_BIT_WIDTH (signed)  sine sample
sin_cos_out_valid  out  1  qualifies cos_out/sin_out

Behaviour:
- Clock and reset: reset rst, synchronous, active-high; clock clk.
- Reset values: phase=0, cos_out=0, sin_out=0, sin_cos_out_valid=0, all pipeline valids 0.
- Reset does not clear table RAM contents.
- Table write: there is no write enable. Each table RAM write port writes data to address on every clk edge, including during reset.
  - Holding a constant address/data pair is harmless.
  - Callers load all 2048 entries before streaming samples.
- Phase accumulator: unsigned VCO_BIT_WIDTH register.
  - On a cycle with voltage_signal_valid=1: phase <= phase + voltage_signal (two's complement, modulo 2^VCO_BIT_WIDTH, natural wrap, no saturation).
  - With valid=0, phase holds.
- Lookup address: phase[VCO_BIT_WIDTH-1 -: SIN_COS_ADDR_BIT_WIDTH], i.e. truncated top 11 bits of the updated phase.
  - The first output uses phase after the first increment.
  - Address step per LSB of address = 2^(VCO_BIT_WIDTH-SIN_COS_ADDR_BIT_WIDTH) = 32.
- Pipeline latency is fixed at 2 clocks from input valid to output valid:
  - Cycle N: valid input sampled, phase register updated.
  - Cycle N+1: RAM read port registers address/data.
  - Cycle N+2: sin_cos_out_valid=1 with cos_out=cos_table[addr], sin_out=sin_table[addr].
- sin_cos_out_valid is a one-cycle pulse per input valid. Back-to-back valid inputs (every cycle) are supported at full rate; the system uses every other cycle (8 Msps).
- cos_out/sin_out hold their last value while valid=0.
- A write to the address being read in the same cycle returns the old data (read-first).
- Reset mid-stream: in-flight samples are dropped (no valid pulses) and phase restarts at 0.

Optional Feature:
- Macro VCO_ROUND_ADDR_EN.
- Defined: the lookup address is rounded, i.e. (phase + 2^(VCO_BIT_WIDTH-SIN_COS_ADDR_BIT_WIDTH-1)) top bits, wrapping modulo 2^SIN_COS_ADDR_BIT_WIDTH. Latency is unchanged.
- Undefined (default, bit-exact with the Python model): truncation as above.

Decomposition:
- Package btle_vco_pkg holds:
  - default width constants (16/11/8);
  - TABLE_DEPTH = 2^SIN_COS_ADDR_BIT_WIDTH;
  - ADDR_SHIFT = VCO_BIT_WIDTH - SIN_COS_ADDR_BIT_WIDTH.
- One sub-module, vco_dpram: simple dual-port RAM (write port plus registered read port, parameterised width/depth), instantiated twice (cos, sin).

Test Plan:
- Load tables cos[k]=round(127*cos(2πk/2048)), sin[k]=round(127*sin(2πk/2048)). Stream voltage=0 ×10 -> 10 outputs, each cos=127, sin=0, valid 2 cycles after each input.
- Stream voltage=32 ×4 -> addresses 1,2,3,4 -> outputs cos[1..4]/sin[1..4] in order.
- Stream voltage=16384 (quarter turn) ×4 -> addresses 512,1024,1536,0 -> (cos,sin) = (0,127),(-127,0),(0,-127),(127,0).
- Wrap: stream 32767, 32767, 2 -> phase 32767, 65534, 0 (wrap) -> addresses 1023, 2047, 0. Then -32 -> phase 65504 -> address 2047.
- Valid gaps: alternate valid/invalid with voltage=32; insert an invalid cycle carrying voltage=9999 -> ignored, phase unchanged, output count equals input count.
- Assert rst for 2 cycles mid-stream -> valid drops to 0 within 1 cycle, outputs 0, no pending pulses. Restart with voltage=32 -> first address 1.

Source files
------------

// File: rtl/btle_vco_pkg.sv
// -----------------------------------------------------------------------------
// btle_vco_pkg
// Shared constants for the BTLE GFSK digital VCO.
//   VCO_W_DEF   : default phase accumulator / voltage sample width
//   ADDR_W_DEF  : default cos/sin table address width
//   IQ_W_DEF    : default signed width of table entries and IQ outputs
//   TABLE_DEPTH : entries per table
//   ADDR_SHIFT  : phase LSBs dropped when forming the table address
// -----------------------------------------------------------------------------
package btle_vco_pkg;

  localparam int VCO_W_DEF   = 16;
  localparam int ADDR_W_DEF  = 11;
  localparam int IQ_W_DEF    = 8;
  localparam int TABLE_DEPTH = 1 << ADDR_W_DEF;
  localparam int ADDR_SHIFT  = VCO_W_DEF - ADDR_W_DEF;

endpackage

// File: rtl/vco_dpram.sv
// -----------------------------------------------------------------------------
// vco_dpram
// Simple dual-port RAM: one write port that writes on every clock edge (no
// enable, not affected by reset) and one read port with a registered output.
// A read and write to the same address in one cycle returns the old contents.
//   clk      : clock
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address, sampled on clk
//   rd_data  : registered read data, valid one clock after rd_addr
// -----------------------------------------------------------------------------
module vco_dpram
  import btle_vco_pkg::*;
#(
  parameter int DATA_W = IQ_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Non-blocking read of mem gives read-first behaviour on an address clash.
  always_ff @(posedge clk) begin
    mem[wr_addr] <= wr_data;
    rd_data_q    <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/btle_vco.sv
// -----------------------------------------------------------------------------
// btle_vco
// Digital VCO for the BTLE GFSK transmitter. Integrates a signed frequency
// sample into a wrapping phase accumulator and looks the phase up in two
// runtime-loadable cos/sin tables. Output latency is 2 clocks.
//   clk, rst                       : clock, synchronous active-high reset
//   cos_table_write_address/_data  : cos table write port (writes every clk)
//   sin_table_write_address/_data  : sin table write port (writes every clk)
//   voltage_signal(_valid)         : signed phase increment and its qualifier
//   cos_out, sin_out               : signed IQ samples, held between pulses
//   sin_cos_out_valid              : one-cycle pulse per accepted input
// Build option VCO_ROUND_ADDR_EN: round the phase to the nearest table entry
// instead of truncating it (default: truncation, bit-exact with the model).
// -----------------------------------------------------------------------------
module btle_vco
  import btle_vco_pkg::*;
#(
  parameter int VCO_BIT_WIDTH          = VCO_W_DEF,
  parameter int SIN_COS_ADDR_BIT_WIDTH = ADDR_W_DEF,
  parameter int IQ_BIT_WIDTH           = IQ_W_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [SIN_COS_ADDR_BIT_WIDTH-1:0]   cos_table_write_address,
  input  logic signed [IQ_BIT_WIDTH-1:0]      cos_table_write_data,
  input  logic [SIN_COS_ADDR_BIT_WIDTH-1:0]   sin_table_write_address,
  input  logic signed [IQ_BIT_WIDTH-1:0]      sin_table_write_data,
  input  logic signed [VCO_BIT_WIDTH-1:0]     voltage_signal,
  input  logic                                voltage_signal_valid,
  output logic signed [IQ_BIT_WIDTH-1:0]      cos_out,
  output logic signed [IQ_BIT_WIDTH-1:0]      sin_out,
  output logic                                sin_cos_out_valid
);

  localparam int VW    = VCO_BIT_WIDTH;
  localparam int AW    = SIN_COS_ADDR_BIT_WIDTH;
  localparam int IW    = IQ_BIT_WIDTH;
  localparam int SHIFT = VW - AW;

`ifdef VCO_ROUND_ADDR_EN
  localparam logic [VW-1:0] HALF_STEP = VW'(1) << (SHIFT - 1);

  // Adding half an address step before truncating rounds to nearest;
  // the modulo-2^VW sum makes the top entry wrap back to address 0.
  function automatic logic [AW-1:0] lookup_addr(input logic [VW-1:0] phase);
    logic [VW-1:0] rounded;
    rounded = phase + HALF_STEP;
    return rounded[VW-1 -: AW];
  endfunction
`else
  function automatic logic [AW-1:0] lookup_addr(input logic [VW-1:0] phase);
    return phase[VW-1 -: AW];
  endfunction
`endif

  logic [VW-1:0]        phase_q, phase_d;
  logic                 vld_p0_q, vld_p0_d;
  logic                 vld_p1_q, vld_p1_d;
  logic                 out_vld_q, out_vld_d;
  logic signed [IW-1:0] cos_q, cos_d;
  logic signed [IW-1:0] sin_q, sin_d;
  logic [AW-1:0]        rd_addr;
  logic [IW-1:0]        cos_rd, sin_rd;

  // Stage p0: accumulate phase (natural two's-complement wrap).
  // Stage p1: table RAMs register the address formed from the updated phase.
  // Stage p2: capture table data into the output registers.
  always_comb begin
    phase_d = phase_q;
    if (voltage_signal_valid) begin
      phase_d = phase_q + $unsigned(voltage_signal);
    end
    vld_p0_d  = voltage_signal_valid;
    vld_p1_d  = vld_p0_q;
    out_vld_d = vld_p1_q;
    cos_d     = cos_q;
    sin_d     = sin_q;
    if (vld_p1_q) begin
      cos_d = $signed(cos_rd);
      sin_d = $signed(sin_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= '0;
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      out_vld_q <= 1'b0;
      cos_q     <= '0;
      sin_q     <= '0;
    end else begin
      phase_q   <= phase_d;
      vld_p0_q  <= vld_p0_d;
      vld_p1_q  <= vld_p1_d;
      out_vld_q <= out_vld_d;
      cos_q     <= cos_d;
      sin_q     <= sin_d;
    end
  end

  assign rd_addr = lookup_addr(phase_q);

  vco_dpram #(.DATA_W(IW), .ADDR_W(AW)) u_cos_ram (
    .clk     (clk),
    .wr_addr (cos_table_write_address),
    .wr_data (cos_table_write_data),
    .rd_addr (rd_addr),
    .rd_data (cos_rd)
  );

  vco_dpram #(.DATA_W(IW), .ADDR_W(AW)) u_sin_ram (
    .clk     (clk),
    .wr_addr (sin_table_write_address),
    .wr_data (sin_table_write_data),
    .rd_addr (rd_addr),
    .rd_data (sin_rd)
  );

  assign cos_out           = cos_q;
  assign sin_out           = sin_q;
  assign sin_cos_out_valid = out_vld_q;

endmodule

// File: tb/tb_btle_vco.sv
// -----------------------------------------------------------------------------
// tb_btle_vco
// Self-checking bench for btle_vco: loads quantised cos/sin tables, streams
// voltage samples, and checks each output pulse against a scoreboard entry
// (table value and arrival cycle) produced from a phase model.
// -----------------------------------------------------------------------------
module tb_btle_vco;

  localparam int VW    = 16;
  localparam int AW    = 11;
  localparam int IW    = 8;
  localparam int DEPTH = 1 << AW;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [AW-1:0]        cos_table_write_address = '0;
  logic signed [IW-1:0] cos_table_write_data = '0;
  logic [AW-1:0]        sin_table_write_address = '0;
  logic signed [IW-1:0] sin_table_write_data = '0;
  logic signed [VW-1:0] voltage_signal = '0;
  logic                 voltage_signal_valid = 1'b0;
  logic signed [IW-1:0] cos_out;
  logic signed [IW-1:0] sin_out;
  logic                 sin_cos_out_valid;

  btle_vco dut (
    .clk                     (clk),
    .rst                     (rst),
    .cos_table_write_address (cos_table_write_address),
    .cos_table_write_data    (cos_table_write_data),
    .sin_table_write_address (sin_table_write_address),
    .sin_table_write_data    (sin_table_write_data),
    .voltage_signal          (voltage_signal),
    .voltage_signal_valid    (voltage_signal_valid),
    .cos_out                 (cos_out),
    .sin_out                 (sin_out),
    .sin_cos_out_valid       (sin_cos_out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [IW-1:0] c;
    logic signed [IW-1:0] s;
    int                   cyc;
  } exp_t;

  exp_t                 sb[$];
  exp_t                 mon_e;
  int                   checks = 0;
  int                   errors = 0;
  int                   cyc    = 0;
  int                   n_in   = 0;
  int                   n_out  = 0;
  logic signed [IW-1:0] cos_tab [DEPTH];
  logic signed [IW-1:0] sin_tab [DEPTH];
  logic [VW-1:0]        model_phase = '0;
  logic signed [IW-1:0] last_c = '0;
  logic signed [IW-1:0] last_s = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [AW-1:0] model_addr(input logic [VW-1:0] p);
    logic [VW-1:0] r;
`ifdef VCO_ROUND_ADDR_EN
    r = p + 16'd16;
`else
    r = p;
`endif
    return r[VW-1 -: AW];
  endfunction

  function automatic logic signed [IW-1:0] q127(input real x);
    real y;
    y = 127.0 * x;
    if (y >= 0.0) return IW'($rtoi(y + 0.5));
    else          return IW'(-$rtoi(-y + 0.5));
  endfunction

  // Scoreboard monitor: every pulse pops one expectation; idle cycles must hold.
  always @(negedge clk) begin
    if (!rst) begin
      if (sin_cos_out_valid === 1'b1) begin
        n_out++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: valid=1 at cycle %0d, required no pulse (queue empty)", cyc);
        end else begin
          mon_e = sb.pop_front();
          checks++;
          if (cos_out !== mon_e.c) begin
            errors++;
            $display("FAIL cos_out: got %0d, required %0d (cycle %0d)", cos_out, mon_e.c, cyc);
          end
          checks++;
          if (sin_out !== mon_e.s) begin
            errors++;
            $display("FAIL sin_out: got %0d, required %0d (cycle %0d)", sin_out, mon_e.s, cyc);
          end
          checks++;
          if (cyc !== mon_e.cyc) begin
            errors++;
            $display("FAIL latency: pulse at cycle %0d, required cycle %0d", cyc, mon_e.cyc);
          end
          last_c = mon_e.c;
          last_s = mon_e.s;
        end
      end else begin
        checks++;
        if (cos_out !== last_c || sin_out !== last_s) begin
          errors++;
          $display("FAIL hold: got cos=%0d sin=%0d, required cos=%0d sin=%0d (cycle %0d)",
                   cos_out, sin_out, last_c, last_s, cyc);
        end
      end
    end
  end

  // Drive one cycle of input; accepted samples push their expected result.
  task automatic step(input logic vld, input logic signed [VW-1:0] v);
    logic [AW-1:0] a;
    voltage_signal_valid = vld;
    voltage_signal       = v;
    if (vld) begin
      model_phase = model_phase + $unsigned(v);
      a = model_addr(model_phase);
      sb.push_back('{cos_tab[a], sin_tab[a], cyc + 3});
      n_in++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) step(1'b0, '0);
    step(1'b0, '0);
    step(1'b0, '0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d outputs still pending, required 0", name, sb.size());
    end
    checks++;
    if (n_out != n_in) begin
      errors++;
      $display("FAIL %s_count: got %0d outputs, required %0d", name, n_out, n_in);
    end
  endtask

  task automatic do_reset(input int n);
    rst                  = 1'b1;
    voltage_signal_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    sb.delete();
    model_phase = '0;
    last_c      = '0;
    last_s      = '0;
    n_in        = 0;
    n_out       = 0;
    rst         = 1'b0;
  endtask

  // Tables are loaded while rst is held, which also exercises writes in reset.
  task automatic test_reset;
    for (int k = 0; k < DEPTH; k++) begin
      cos_tab[k] = q127($cos(2.0 * 3.141592653589793 * k / DEPTH));
      sin_tab[k] = q127($sin(2.0 * 3.141592653589793 * k / DEPTH));
    end
    for (int k = 0; k < DEPTH; k++) begin
      cos_table_write_address = AW'(k);
      cos_table_write_data    = cos_tab[k];
      sin_table_write_address = AW'(k);
      sin_table_write_data    = sin_tab[k];
      @(posedge clk);
      #1;
    end
    checks++;
    if (sin_cos_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b, required 0", sin_cos_out_valid);
    end
    checks++;
    if (cos_out !== 8'sd0 || sin_out !== 8'sd0) begin
      errors++;
      $display("FAIL reset_outputs: got cos=%0d sin=%0d, required 0/0", cos_out, sin_out);
    end
    do_reset(1);
    repeat (3) step(1'b0, '0);
  endtask

  task automatic test_zero_back_to_back;
    do_reset(2);
    repeat (10) step(1'b1, 16'sd0);
    drain("zero");
  endtask

  task automatic test_small_step;
    do_reset(2);
    repeat (4) step(1'b1, 16'sd32);
    drain("step32");
  endtask

  task automatic test_quarter_turn;
    do_reset(2);
    repeat (4) step(1'b1, 16'sd16384);
    drain("quarter");
  endtask

  task automatic test_wrap;
    do_reset(2);
    step(1'b1, 16'sd32767);
    step(1'b1, 16'sd32767);
    step(1'b1, 16'sd2);
    step(1'b1, -16'sd32);
    drain("wrap");
  endtask

  task automatic test_gaps;
    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'sd32);
      step(1'b0, (i == 2) ? 16'sd9999 : 16'sd32);
    end
    drain("gaps");
  endtask

  task automatic test_reset_midstream;
    do_reset(2);
    repeat (3) step(1'b1, 16'sd32);
    rst                  = 1'b1;
    voltage_signal_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (sin_cos_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_valid: got %b, required 0", sin_cos_out_valid);
    end
    checks++;
    if (cos_out !== 8'sd0 || sin_out !== 8'sd0) begin
      errors++;
      $display("FAIL midreset_outputs: got cos=%0d sin=%0d, required 0/0", cos_out, sin_out);
    end
    do_reset(1);
    repeat (4) step(1'b0, '0);
    step(1'b1, 16'sd32);
    drain("restart");
  endtask

  initial begin
    test_reset();
    test_zero_back_to_back();
    test_small_step();
    test_quarter_turn();
    test_wrap();
    test_gaps();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
